// File: rtl/ipsum_fifo_ctrl_pkg.sv
// Shared token-engine types for the ipsum read path.
// Holds the controller state encoding and the GLB read latency.
package ipsum_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_CAN_POP,
        ST_DONE
    } ipsum_state_t;

    localparam int GLB_RD_LAT = 1;

endpackage

// File: rtl/ipsum_fifo_ctrl.sv
// Ipsum FIFO controller: fetches 16-bit ipsums from the GLB into the
// ipsum FIFO and hands them to the PE array on pe_array_move_i.
module ipsum_fifo_ctrl
    import ipsum_fifo_ctrl_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ipsum_fifo_reset_i,
    input  logic        ipsum_need_pop_i,
    input  logic [31:0] ipsum_pop_num_i,
    input  logic [31:0] ipsum_glb_base_addr_i,
    input  logic        ipsum_fifo_mask_i,
    input  logic        pe_array_move_i,
    input  logic        ipsum_permit_push_i,
    input  logic [31:0] ipsum_glb_read_data_i,
    input  logic        ipsum_fifo_full_i,
    input  logic        ipsum_fifo_empty_i,
    output logic        ipsum_read_req_o,
    output logic [31:0] ipsum_glb_read_addr_o,
    output logic        ipsum_fifo_push_o,
    output logic [31:0] ipsum_fifo_push_data_o,
    output logic        ipsum_fifo_pop_o,
    output logic        ipsum_is_POP_state_o,
    output logic        ipsum_fifo_done_o
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);
    localparam int PEND_W = GLB_RD_LAT;

    ipsum_state_t      state_q;
    logic [31:0]       num_q;
    logic [31:0]       rd_cnt_q;
    logic [31:0]       pop_cnt_q;
    logic [31:0]       pop_cnt_d;
    logic [BW-1:0]     burst_cnt_q;
    logic [PEND_W-1:0] pending_q;
    logic              sel_q;
    logic              pop_state_q;
    logic              done_q;

    logic in_fill;
    logic in_pop;
    logic pend_any;
    logic rd_left;
    logic req;
    logic grant;
    logic pop;
    logic fill_exit;

    assign in_fill  = (state_q == ST_FILL);
    assign in_pop   = (state_q == ST_CAN_POP);
    assign pend_any = |pending_q;
    assign rd_left  = (rd_cnt_q < num_q);

    assign req = in_fill & ~ipsum_fifo_full_i & ~pend_any
               & rd_left & (burst_cnt_q < BURST_LIM);
    assign grant = req & ipsum_permit_push_i;

    assign pop = in_pop & pe_array_move_i
               & ipsum_fifo_mask_i & ~ipsum_fifo_empty_i;
    assign pop_cnt_d = pop_cnt_q + {31'd0, pop};

    // Registered pending keeps the last read's push inside FILL.
    assign fill_exit = ~pend_any & (ipsum_fifo_full_i
                     | (rd_cnt_q == num_q)
                     | (burst_cnt_q == BURST_LIM));

    assign ipsum_read_req_o      = req;
    assign ipsum_glb_read_addr_o = ipsum_glb_base_addr_i
                                 + {rd_cnt_q[30:0], 1'b0};
    assign ipsum_fifo_push_o     = pending_q[PEND_W-1];
    assign ipsum_fifo_push_data_o =
        !pending_q[PEND_W-1] ? 32'd0 :
        sel_q ? {16'd0, ipsum_glb_read_data_i[31:16]}
              : {16'd0, ipsum_glb_read_data_i[15:0]};
    assign ipsum_fifo_pop_o      = pop;
    assign ipsum_is_POP_state_o  = pop_state_q;
    assign ipsum_fifo_done_o     = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            rd_cnt_q    <= '0;
            pop_cnt_q   <= '0;
            burst_cnt_q <= '0;
            pending_q   <= '0;
            sel_q       <= 1'b0;
            pop_state_q <= 1'b0;
            done_q      <= 1'b0;
        end else if (ipsum_fifo_reset_i) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            rd_cnt_q    <= '0;
            pop_cnt_q   <= '0;
            burst_cnt_q <= '0;
            pending_q   <= '0;
            sel_q       <= 1'b0;
            pop_state_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pending_q <= PEND_W'({pending_q, grant});
            if (grant) begin
                rd_cnt_q    <= rd_cnt_q + 32'd1;
                burst_cnt_q <= burst_cnt_q + 1'b1;
                sel_q       <= ipsum_glb_read_addr_o[1];
            end
            if (pop) begin
                pop_cnt_q <= pop_cnt_d;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (ipsum_need_pop_i) begin
                        state_q     <= ST_FILL;
                        num_q       <= ipsum_pop_num_i;
                        rd_cnt_q    <= '0;
                        pop_cnt_q   <= '0;
                        burst_cnt_q <= '0;
                        pending_q   <= '0;
                    end
                end
                ST_FILL: begin
                    if (fill_exit) begin
                        state_q     <= ST_CAN_POP;
                        pop_state_q <= 1'b1;
                    end
                end
                ST_CAN_POP: begin
                    if (pop_cnt_d == num_q) begin
                        state_q     <= ST_DONE;
                        pop_state_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else if (ipsum_fifo_empty_i && rd_left) begin
                        state_q     <= ST_FILL;
                        pop_state_q <= 1'b0;
                        burst_cnt_q <= '0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ipsum_fifo_ctrl.sv
// Directed bench for ipsum_fifo_ctrl with a small GLB and FIFO model.
// Each scenario task checks its own hand-computed expectations.
module tb_ipsum_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_reset = 1'b0;
    logic        need = 1'b0;
    logic [31:0] num = '0;
    logic [31:0] base = '0;
    logic        mask = 1'b1;
    logic        move = 1'b1;
    logic        permit = 1'b1;
    logic [31:0] rdata = '0;
    logic        full;
    logic        empty;
    logic        req;
    logic [31:0] addr;
    logic        push;
    logic [31:0] pdata;
    logic        pop;
    logic        is_pop;
    logic        done;

    int tests = 0;
    int fails = 0;

    int cap = 8;
    int occ = 0;
    int cyc = 0;
    int n_grant = 0;
    int n_push = 0;
    int n_pop = 0;
    int last_pop_cyc = -1;
    int done_cyc = -1;
    int grants_at_pop = -1;
    bit pop_seen = 1'b0;
    bit mon_clr = 1'b0;
    logic [31:0] grant_q[$];
    logic [31:0] push_q[$];

    always #5 clk = ~clk;

    ipsum_fifo_ctrl #(.MAX_BURST(4)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ipsum_fifo_reset_i     (fifo_reset),
        .ipsum_need_pop_i       (need),
        .ipsum_pop_num_i        (num),
        .ipsum_glb_base_addr_i  (base),
        .ipsum_fifo_mask_i      (mask),
        .pe_array_move_i        (move),
        .ipsum_permit_push_i    (permit),
        .ipsum_glb_read_data_i  (rdata),
        .ipsum_fifo_full_i      (full),
        .ipsum_fifo_empty_i     (empty),
        .ipsum_read_req_o       (req),
        .ipsum_glb_read_addr_o  (addr),
        .ipsum_fifo_push_o      (push),
        .ipsum_fifo_push_data_o (pdata),
        .ipsum_fifo_pop_o       (pop),
        .ipsum_is_POP_state_o   (is_pop),
        .ipsum_fifo_done_o      (done)
    );

    assign full  = (occ >= cap);
    assign empty = (occ == 0);

    // GLB word contents: two fixed words, the rest derived from the address.
    function automatic logic [31:0] glb_word(input logic [31:0] w);
        logic [15:0] lo;
        logic [15:0] hi;
        if (w == 32'h100) return 32'hBBBB_AAAA;
        if (w == 32'h104) return 32'hDDDD_CCCC;
        lo = ~w[15:0];
        hi = ~(w[15:0] + 16'd2);
        return {hi, lo};
    endfunction

    always @(posedge clk) begin
        rdata <= glb_word({addr[31:2], 2'b00});
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            n_grant       <= 0;
            n_push        <= 0;
            n_pop         <= 0;
            occ           <= 0;
            last_pop_cyc  <= -1;
            done_cyc      <= -1;
            grants_at_pop <= -1;
            pop_seen      <= 1'b0;
            grant_q.delete();
            push_q.delete();
        end else begin
            if (req && permit) begin
                n_grant <= n_grant + 1;
                grant_q.push_back(addr);
            end
            if (push) begin
                n_push <= n_push + 1;
                push_q.push_back(pdata);
            end
            if (pop) begin
                n_pop        <= n_pop + 1;
                last_pop_cyc <= cyc;
            end
            occ <= occ + int'(push) - int'(pop);
            if (is_pop && !pop_seen) begin
                pop_seen      <= 1'b1;
                grants_at_pop <= n_grant;
            end
            if (done && done_cyc < 0) done_cyc <= cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic soft_reset();
        fifo_reset = 1'b1;
        mon_clr = 1'b1;
        tick();
        fifo_reset = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic start(input logic [31:0] b, input logic [31:0] n);
        base = b;
        num = n;
        need = 1'b1;
        tick();
        need = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int i;
        i = 0;
        while (done !== 1'b1 && i < bound) begin
            tick();
            i++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s: done_o=%b after %0d cycles, required 1",
                     name, done, bound);
        end
    endtask

    task automatic test_reset();
        base = 32'h40;
        #1;
        tests++;
        if ({req, push, pop, is_pop, done} !== 5'b0) begin
            fails++;
            $display("FAIL rst_outs: req/push/pop/popst/done=%b required 00000",
                     {req, push, pop, is_pop, done});
        end
        tests++;
        if (addr !== 32'h40) begin
            fails++;
            $display("FAIL rst_addr: got %h required 00000040", addr);
        end
        tests++;
        if (pdata !== 32'h0) begin
            fails++;
            $display("FAIL rst_pdata: got %h required 00000000", pdata);
        end
        rst_n = 1'b1;
        tick();
        tick();
        tests++;
        if ({req, is_pop, done} !== 3'b0) begin
            fails++;
            $display("FAIL idle_outs: req/popst/done=%b required 000",
                     {req, is_pop, done});
        end
    endtask

    task automatic test_basic();
        soft_reset();
        cap = 8;
        start(32'h100, 32'd3);
        tests++;
        if (req !== 1'b1 || addr !== 32'h100) begin
            fails++;
            $display("FAIL basic_first_req: req=%b addr=%h required 1 00000100",
                     req, addr);
        end
        wait_done(60, "basic_done");
        tick();
        tests++;
        if (grant_q.size() !== 3) begin
            fails++;
            $display("FAIL basic_ngrant: got %0d required 3", grant_q.size());
        end else begin
            tests++;
            if (grant_q[0] !== 32'h100 || grant_q[1] !== 32'h102
                || grant_q[2] !== 32'h104) begin
                fails++;
                $display("FAIL basic_addrs: got %h %h %h required 100 102 104",
                         grant_q[0], grant_q[1], grant_q[2]);
            end
        end
        tests++;
        if (push_q.size() !== 3) begin
            fails++;
            $display("FAIL basic_npush: got %0d required 3", push_q.size());
        end else begin
            tests++;
            if (push_q[0] !== 32'h0000AAAA || push_q[1] !== 32'h0000BBBB
                || push_q[2] !== 32'h0000CCCC) begin
                fails++;
                $display("FAIL basic_data: got %h %h %h required AAAA BBBB CCCC",
                         push_q[0], push_q[1], push_q[2]);
            end
        end
        tests++;
        if (n_pop !== 3) begin
            fails++;
            $display("FAIL basic_npop: got %0d required 3", n_pop);
        end
        tests++;
        if (done_cyc !== last_pop_cyc + 1) begin
            fails++;
            $display("FAIL basic_done_lat: done at %0d last pop %0d required +1",
                     done_cyc, last_pop_cyc);
        end
    endtask

    task automatic test_burst();
        soft_reset();
        cap = 16;
        start(32'h200, 32'd10);
        wait_done(200, "burst_done");
        tick();
        tests++;
        if (grants_at_pop !== 4) begin
            fails++;
            $display("FAIL burst_first: grants before CAN_POP %0d required 4",
                     grants_at_pop);
        end
        tests++;
        if (n_grant !== 10 || n_push !== 10 || n_pop !== 10) begin
            fails++;
            $display("FAIL burst_totals: grant/push/pop %0d/%0d/%0d required 10/10/10",
                     n_grant, n_push, n_pop);
        end
        tests++;
        if (grant_q.size() < 10 || push_q.size() < 10) begin
            fails++;
            $display("FAIL burst_qsize: grants %0d pushes %0d required 10",
                     grant_q.size(), push_q.size());
        end else begin
            tests++;
            if (grant_q[4] !== 32'h208 || grant_q[9] !== 32'h212) begin
                fails++;
                $display("FAIL burst_refill_addr: got %h %h required 208 212",
                         grant_q[4], grant_q[9]);
            end
            tests++;
            if (push_q[4] !== 32'h0000FDF7 || push_q[5] !== 32'h0000FDF5) begin
                fails++;
                $display("FAIL burst_data: got %h %h required FDF7 FDF5",
                         push_q[4], push_q[5]);
            end
        end
    endtask

    task automatic test_full_mask();
        int i;
        soft_reset();
        cap = 2;
        mask = 1'b0;
        move = 1'b1;
        start(32'h300, 32'd5);
        i = 0;
        while (is_pop !== 1'b1 && i < 30) begin
            tick();
            i++;
        end
        tests++;
        if (is_pop !== 1'b1) begin
            fails++;
            $display("FAIL full_enter: is_POP=%b required 1", is_pop);
        end
        tests++;
        if (n_push !== 2 || push !== 1'b0 || req !== 1'b0) begin
            fails++;
            $display("FAIL full_stop: pushes=%0d push=%b req=%b required 2 0 0",
                     n_push, push, req);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (pop !== 1'b0 || is_pop !== 1'b1) begin
                fails++;
                $display("FAIL mask_hold%0d: pop=%b is_POP=%b required 0 1",
                         k, pop, is_pop);
            end
            tick();
        end
        tests++;
        if (n_push !== 2) begin
            fails++;
            $display("FAIL full_no_third: pushes=%0d required 2", n_push);
        end
        mask = 1'b1;
        #1;
        tests++;
        if (pop !== 1'b1) begin
            fails++;
            $display("FAIL mask_resume: pop=%b required 1", pop);
        end
        wait_done(200, "full_done");
        tick();
        tests++;
        if (n_push !== 5 || n_pop !== 5) begin
            fails++;
            $display("FAIL full_totals: push/pop %0d/%0d required 5/5",
                     n_push, n_pop);
        end
    endtask

    task automatic test_sync_reset();
        soft_reset();
        cap = 8;
        start(32'h100, 32'd3);
        tests++;
        if (req !== 1'b1) begin
            fails++;
            $display("FAIL srst_req: req=%b required 1", req);
        end
        fifo_reset = 1'b1;
        tick();
        fifo_reset = 1'b0;
        tests++;
        if ({push, req, is_pop, done} !== 4'b0) begin
            fails++;
            $display("FAIL srst_outs: push/req/popst/done=%b required 0000",
                     {push, req, is_pop, done});
        end
        tests++;
        if (addr !== 32'h100 || pdata !== 32'h0) begin
            fails++;
            $display("FAIL srst_cnt: addr=%h pdata=%h required 00000100 0",
                     addr, pdata);
        end
        tick();
        tick();
        tick();
        tests++;
        if (n_push !== 0 || req !== 1'b0) begin
            fails++;
            $display("FAIL srst_idle: pushes=%0d req=%b required 0 0",
                     n_push, req);
        end
    endtask

    task automatic test_num_zero();
        soft_reset();
        start(32'h40, 32'd0);
        tests++;
        if ({req, is_pop, done} !== 3'b000) begin
            fails++;
            $display("FAIL zero_t1: req/popst/done=%b required 000",
                     {req, is_pop, done});
        end
        tick();
        tests++;
        if ({req, is_pop, done} !== 3'b010) begin
            fails++;
            $display("FAIL zero_t2: req/popst/done=%b required 010",
                     {req, is_pop, done});
        end
        tick();
        tests++;
        if ({req, is_pop, done} !== 3'b001) begin
            fails++;
            $display("FAIL zero_t3: req/popst/done=%b required 001",
                     {req, is_pop, done});
        end
        tick();
        tick();
        tick();
        tests++;
        if (done !== 1'b1 || n_grant !== 0 || n_pop !== 0) begin
            fails++;
            $display("FAIL zero_hold: done=%b grants=%0d pops=%0d required 1 0 0",
                     done, n_grant, n_pop);
        end
        soft_reset();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL zero_clear: done=%b required 0", done);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        test_reset();
        test_basic();
        test_burst();
        test_full_mask();
        test_sync_reset();
        test_num_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
